// File: rtl/sram_dump.sv
// SRAM-to-flash image dumper: writes a 4-word header, the instruction and data payloads,
// and optionally (when DUMP_CHECKSUM_EN is defined) a 32-bit wrapping checksum word.
module sram_dump #(
  parameter logic [24:0] FLASH_BASE = 25'd0,
  parameter logic [31:0] SIZE_LIMIT = 32'h003F_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startFlag,
  input  logic [21:0] instAddr,
  input  logic [31:0] instSize,
  input  logic [21:0] dataAddr,
  input  logic [31:0] dataSize,
  input  logic        sramReady,
  input  logic [31:0] sramData,
  output logic [21:0] sramAddr,
  output logic        sramCs,
  input  logic        flashReady,
  output logic [24:0] flashAddr,
  output logic [31:0] flashData,
  output logic        flashCs,
  output logic        busy,
  output logic        led
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_HDR, S_FWAIT, S_SREQ, S_SWAIT,
    S_SCAP, S_PWR, S_PWAIT, S_DONE, S_ERR
  } state_t;

  typedef enum logic [1:0] {R_INST, R_DATA, R_SUM} region_t;

  state_t      state_q, state_d;
  region_t     region_q, region_d;
  logic [21:0] inst_addr_q, inst_addr_d;
  logic [31:0] inst_size_q, inst_size_d;
  logic [21:0] data_addr_q, data_addr_d;
  logic [31:0] data_size_q, data_size_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [24:0] flash_addr_q, flash_addr_d;
  logic [31:0] flash_data_q, flash_data_d;
  logic [21:0] sram_addr_q, sram_addr_d;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic start_inst, start_data, to_tail;

  // Strobes are decoded from the state so a write/read lasts exactly the one
  // cycle in which the write/request state sees the peer ready.
  assign flashCs   = ((state_q == S_HDR) || (state_q == S_PWR)) && flashReady;
  assign sramCs    = (state_q == S_SREQ) && sramReady;
  assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign led       = (state_q != S_DONE);
  assign flashAddr = flash_addr_q;
  assign flashData = flash_data_q;
  assign sramAddr  = sram_addr_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d      = state_q;
    region_d     = region_q;
    inst_addr_d  = inst_addr_q;
    inst_size_d  = inst_size_q;
    data_addr_d  = data_addr_q;
    data_size_d  = data_size_q;
    hdr_idx_d    = hdr_idx_q;
    cnt_d        = cnt_q;
    flash_addr_d = flash_addr_q;
    flash_data_d = flash_data_q;
    sram_addr_d  = sram_addr_q;
`ifdef DUMP_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    start_inst   = 1'b0;
    start_data   = 1'b0;
    to_tail      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (startFlag) begin
          inst_addr_d = instAddr;
          inst_size_d = instSize;
          data_addr_d = dataAddr;
          data_size_d = dataSize;
          hdr_idx_d   = 2'd0;
          cnt_d       = '0;
`ifdef DUMP_CHECKSUM_EN
          sum_d       = '0;
`endif
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((inst_size_q > SIZE_LIMIT) || (data_size_q > SIZE_LIMIT)) begin
          state_d = S_ERR;
        end else begin
          flash_addr_d = FLASH_BASE;
          flash_data_d = {10'b0, inst_addr_q};
          state_d      = S_HDR;
        end
      end
      S_HDR:   if (flashReady) state_d = S_FWAIT;
      S_FWAIT: begin
        if (hdr_idx_q == 2'd3) begin
          if (inst_size_q != '0)      start_inst = 1'b1;
          else if (data_size_q != '0) start_data = 1'b1;
          else                        to_tail    = 1'b1;
        end else begin
          hdr_idx_d    = hdr_idx_q + 2'd1;
          flash_addr_d = flash_addr_q + 25'd1;
          unique case (hdr_idx_q)
            2'd0:    flash_data_d = inst_size_q;
            2'd1:    flash_data_d = {10'b0, data_addr_q};
            default: flash_data_d = data_size_q;
          endcase
          state_d = S_HDR;
        end
      end
      S_SREQ:  if (sramReady) state_d = S_SWAIT;
      S_SWAIT: state_d = S_SCAP;
      S_SCAP: begin
        if (sramReady) begin
          flash_data_d = sramData;
          flash_addr_d = flash_addr_q + 25'd1;
`ifdef DUMP_CHECKSUM_EN
          sum_d        = sum_q + sramData;
`endif
          state_d      = S_PWR;
        end
      end
      S_PWR:   if (flashReady) state_d = S_PWAIT;
      S_PWAIT: begin
        unique case (region_q)
          R_INST: begin
            if (cnt_q + 32'd1 == inst_size_q) begin
              if (data_size_q != '0) start_data = 1'b1;
              else                   to_tail    = 1'b1;
            end else begin
              cnt_d       = cnt_q + 32'd1;
              sram_addr_d = sram_addr_q + 22'd1;
              state_d     = S_SREQ;
            end
          end
          R_DATA: begin
            if (cnt_q + 32'd1 == data_size_q) begin
              to_tail = 1'b1;
            end else begin
              cnt_d       = cnt_q + 32'd1;
              sram_addr_d = sram_addr_q + 22'd1;
              state_d     = S_SREQ;
            end
          end
          default: state_d = S_DONE;
        endcase
      end
      S_DONE, S_ERR: if (!startFlag) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start_inst) begin
      region_d    = R_INST;
      cnt_d       = '0;
      sram_addr_d = inst_addr_q;
      state_d     = S_SREQ;
    end
    if (start_data) begin
      region_d    = R_DATA;
      cnt_d       = '0;
      sram_addr_d = data_addr_q;
      state_d     = S_SREQ;
    end
    if (to_tail) begin
`ifdef DUMP_CHECKSUM_EN
      region_d     = R_SUM;
      flash_addr_d = flash_addr_q + 25'd1;
      flash_data_d = sum_q;
      state_d      = S_PWR;
`else
      state_d      = S_DONE;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      region_q     <= R_INST;
      inst_addr_q  <= '0;
      inst_size_q  <= '0;
      data_addr_q  <= '0;
      data_size_q  <= '0;
      hdr_idx_q    <= '0;
      cnt_q        <= '0;
      flash_addr_q <= '0;
      flash_data_q <= '0;
      sram_addr_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      inst_addr_q  <= inst_addr_d;
      inst_size_q  <= inst_size_d;
      data_addr_q  <= data_addr_d;
      data_size_q  <= data_size_d;
      hdr_idx_q    <= hdr_idx_d;
      cnt_q        <= cnt_d;
      flash_addr_q <= flash_addr_d;
      flash_data_q <= flash_data_d;
      sram_addr_q  <= sram_addr_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

endmodule
